// File: rtl/seq_mul_pkg.sv
// Shared definitions for the sequential shift-and-add multiplier.
package seq_mul_pkg;

  // State encoding shared by the controller and anything observing it.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_CALC = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } state_e;

  // Ceiling log2, used to size the iteration counter.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < value) r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/seq_mul_datapath.sv
// Datapath: operand capture, magnitude conversion, shift-and-add
// accumulation, final sign fix-up and multiplier zero-detect.
module seq_mul_datapath
  import seq_mul_pkg::*;
#(
  parameter int WIDTH = 8,
  localparam int CW = clog2(WIDTH) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cap_i,
  input  logic               load_i,
  input  logic               step_i,
  input  logic               fix_i,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic               cnt_last_o,
  output logic               rem_zero_o,
  output logic [2*WIDTH-1:0] acc_fix_o,
  output logic [CW-1:0]      cnt_o
);

  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               sgn_q, sgn_d;
  logic               neg_q, neg_d;
  logic [WIDTH-1:0]   a_mag, b_mag;

  // Next-state logic for all datapath registers, selected by the FSM strobes.
  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    sgn_d    = sgn_q;
    neg_d    = neg_q;
    // -2^(W-1) maps onto itself, which read unsigned is the correct magnitude.
    a_mag = mcand_q[WIDTH-1:0];
    if (sgn_q && mcand_q[WIDTH-1]) a_mag = -mcand_q[WIDTH-1:0];
    b_mag = mplier_q;
    if (sgn_q && mplier_q[WIDTH-1]) b_mag = -mplier_q;
    if (cap_i) begin
      mcand_d  = {{WIDTH{1'b0}}, multiplicand};
      mplier_d = multiplier;
      sgn_d    = signed_mode;
    end else if (load_i) begin
      mcand_d  = {{WIDTH{1'b0}}, a_mag};
      mplier_d = b_mag;
      neg_d    = sgn_q & (mcand_q[WIDTH-1] ^ mplier_q[WIDTH-1]);
      acc_d    = '0;
      cnt_d    = '0;
    end else if (step_i) begin
      if (mplier_q[0]) acc_d = acc_q + mcand_q;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + CW'(1);
    end else if (fix_i) begin
      if (neg_q) acc_d = -acc_q;
    end
  end

  // Datapath registers with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      sgn_q    <= 1'b0;
      neg_q    <= 1'b0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      sgn_q    <= sgn_d;
      neg_q    <= neg_d;
    end
  end

  assign cnt_last_o = (cnt_q == CW'(WIDTH - 1));
  assign rem_zero_o = (mplier_q[WIDTH-1:1] == '0);
  assign acc_fix_o  = neg_q ? -acc_q : acc_q;
  assign cnt_o      = cnt_q;

endmodule

// File: rtl/seq_mul_shift_add.sv
// Sequential shift-and-add multiplier: controller FSM and output registers.
module seq_mul_shift_add
  import seq_mul_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter bit EARLY_TERM = 1'b0,
  localparam int CW = clog2(WIDTH) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product,
  output logic [CW-1:0]      cycles
);

  state_e             state_q, state_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [2*WIDTH-1:0] product_q, product_d;
  logic [CW-1:0]      cycles_q, cycles_d;
  logic               cap, load, step, fix;
  logic               cnt_last, rem_zero;
  logic [2*WIDTH-1:0] acc_fix;
  logic [CW-1:0]      cnt;

  assign cap  = start && (state_q == ST_IDLE || state_q == ST_DONE);
  assign load = (state_q == ST_LOAD);
  assign step = (state_q == ST_CALC);
  assign fix  = (state_q == ST_FIX);

  seq_mul_datapath #(.WIDTH(WIDTH)) u_dp (
    .clk          (clk),
    .rst          (rst),
    .cap_i        (cap),
    .load_i       (load),
    .step_i       (step),
    .fix_i        (fix),
    .signed_mode  (signed_mode),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .cnt_last_o   (cnt_last),
    .rem_zero_o   (rem_zero),
    .acc_fix_o    (acc_fix),
    .cnt_o        (cnt)
  );

  // Next state and next values of the registered outputs.
  always_comb begin
    state_d   = state_q;
    done_d    = 1'b0;
    product_d = product_q;
    cycles_d  = cycles_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_LOAD;
      ST_LOAD: state_d = ST_CALC;
      ST_CALC: if (cnt_last || (EARLY_TERM && rem_zero)) state_d = ST_FIX;
      ST_FIX: begin
        state_d   = ST_DONE;
        done_d    = 1'b1;
        product_d = acc_fix;
        cycles_d  = cnt;
      end
      ST_DONE: state_d = start ? ST_LOAD : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d == ST_LOAD) || (state_d == ST_CALC) || (state_d == ST_FIX);
  end

  // FSM state and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      product_q <= '0;
      cycles_q  <= '0;
    end else begin
      state_q   <= state_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      product_q <= product_d;
      cycles_q  <= cycles_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = product_q;
  assign cycles  = cycles_q;

endmodule
